// File: rtl/window_scan_if.sv
// Valid/ready scan-coordinate stream between the window scan generator
// and the pixel-fetch / compare pipeline.
interface window_scan_if #(
  parameter int ROW_W = 10,
  parameter int COL_W = 10
);
  logic             start;
  logic             ready;
  logic             valid;
  logic [ROW_W-1:0] win_row;
  logic [COL_W-1:0] win_col;
  logic [ROW_W-1:0] pix_row;
  logic [COL_W-1:0] pix_col;
  logic             win_first;
  logic             win_last;
  logic             frame_last;
  logic             busy;
  logic             done;

  modport master (
    input  start,
    input  ready,
    output valid,
    output win_row,
    output win_col,
    output pix_row,
    output pix_col,
    output win_first,
    output win_last,
    output frame_last,
    output busy,
    output done
  );

  modport slave (
    output start,
    output ready,
    input  valid,
    input  win_row,
    input  win_col,
    input  pix_row,
    input  pix_col,
    input  win_first,
    input  win_last,
    input  frame_last,
    input  busy,
    input  done
  );
endinterface

// File: rtl/window_scan_gen.sv
// Template-search scan address generator: walks every pixel of every
// strided window origin over the image as a registered valid/ready stream.
module window_scan_gen #(
  parameter int ROW_W    = 10,
  parameter int COL_W    = 10,
  parameter int IMG_ROWS = 480,
  parameter int IMG_COLS = 640,
  parameter int WIN_ROWS = 8,
  parameter int WIN_COLS = 8,
  parameter int STRIDE   = 1
) (
  input logic            clk,
  input logic            rst,
  window_scan_if.master  scan_o
);

  localparam int S   = (STRIDE < 1) ? 1 : STRIDE;
  localparam int NWR = (IMG_ROWS - WIN_ROWS) / S + 1;
  localparam int NWC = (IMG_COLS - WIN_COLS) / S + 1;

  localparam logic [ROW_W-1:0] OR_MAX = ROW_W'(WIN_ROWS - 1);
  localparam logic [COL_W-1:0] OC_MAX = COL_W'(WIN_COLS - 1);
  localparam logic [ROW_W-1:0] WR_MAX = ROW_W'((NWR - 1) * S);
  localparam logic [COL_W-1:0] WC_MAX = COL_W'((NWC - 1) * S);
  localparam logic [ROW_W-1:0] R_STEP = ROW_W'(S);
  localparam logic [COL_W-1:0] C_STEP = COL_W'(S);

  generate
    if (WIN_ROWS < 1 || WIN_ROWS > IMG_ROWS) begin : g_err_wr
      $error("window_scan_gen: WIN_ROWS out of range");
    end
    if (WIN_COLS < 1 || WIN_COLS > IMG_COLS) begin : g_err_wc
      $error("window_scan_gen: WIN_COLS out of range");
    end
    if (STRIDE < 1) begin : g_err_s
      $error("window_scan_gen: STRIDE must be >= 1");
    end
    if (((IMG_ROWS - 1) >> ROW_W) != 0) begin : g_err_rw
      $error("window_scan_gen: IMG_ROWS-1 does not fit ROW_W");
    end
    if (((IMG_COLS - 1) >> COL_W) != 0) begin : g_err_cw
      $error("window_scan_gen: IMG_COLS-1 does not fit COL_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             first_q, first_d;
  logic             last_q, last_d;
  logic             flast_q, flast_d;
  logic [ROW_W-1:0] off_row_q, off_row_d;
  logic [COL_W-1:0] off_col_q, off_col_d;
  logic [ROW_W-1:0] win_row_q, win_row_d;
  logic [COL_W-1:0] win_col_q, win_col_d;
  logic [ROW_W-1:0] pix_row_q, pix_row_d;
  logic [COL_W-1:0] pix_col_q, pix_col_d;

  logic             oc_wrap, or_wrap, wc_wrap, wr_wrap;
  logic [COL_W-1:0] oc_n, wc_n;
  logic [ROW_W-1:0] or_n, wr_n;
  logic             xfer, load, adv, clr;

  // Odometer increment of the current counters, innermost column first
  always_comb begin
    oc_wrap = (off_col_q == OC_MAX);
    or_wrap = (off_row_q == OR_MAX);
    wc_wrap = (win_col_q == WC_MAX);
    wr_wrap = (win_row_q == WR_MAX);
    oc_n    = oc_wrap ? '0 : off_col_q + COL_W'(1);
    or_n    = off_row_q;
    wc_n    = win_col_q;
    wr_n    = win_row_q;
    if (oc_wrap) begin
      or_n = or_wrap ? '0 : off_row_q + ROW_W'(1);
    end
    if (oc_wrap && or_wrap) begin
      wc_n = wc_wrap ? '0 : win_col_q + C_STEP;
    end
    if (oc_wrap && or_wrap && wc_wrap) begin
      wr_n = wr_wrap ? '0 : win_row_q + R_STEP;
    end
  end

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = done_q;
    first_d   = first_q;
    last_d    = last_q;
    flast_d   = flast_q;
    off_row_d = off_row_q;
    off_col_d = off_col_q;
    win_row_d = win_row_q;
    win_col_d = win_col_q;
    pix_row_d = pix_row_q;
    pix_col_d = pix_col_q;
    xfer      = valid_q & scan_o.ready;
    load      = 1'b0;
    adv       = 1'b0;
    clr       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (scan_o.start) begin
          state_d = SCAN;
          load    = 1'b1;
        end
      end
      SCAN: begin
        if (xfer && flast_q) begin
          state_d = DONE;
          clr     = 1'b1;
          done_d  = 1'b1;
        end else if (xfer) begin
          adv = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        clr     = 1'b1;
        done_d  = 1'b0;
      end
    endcase

    unique case (1'b1)
      load: begin
        off_row_d = '0;
        off_col_d = '0;
        win_row_d = '0;
        win_col_d = '0;
      end
      adv: begin
        off_row_d = or_n;
        off_col_d = oc_n;
        win_row_d = wr_n;
        win_col_d = wc_n;
      end
      default: ;
    endcase

    // Flags come from the next-state counters so they ride with their beat
    if (load || adv) begin
      valid_d   = 1'b1;
      busy_d    = 1'b1;
      pix_row_d = win_row_d + off_row_d;
      pix_col_d = win_col_d + off_col_d;
      first_d   = (off_row_d == '0) && (off_col_d == '0);
      last_d    = (off_row_d == OR_MAX) && (off_col_d == OC_MAX);
      flast_d   = last_d && (win_row_d == WR_MAX) &&
                  (win_col_d == WC_MAX);
    end

    if (clr) begin
      valid_d   = 1'b0;
      busy_d    = 1'b0;
      first_d   = 1'b0;
      last_d    = 1'b0;
      flast_d   = 1'b0;
      off_row_d = '0;
      off_col_d = '0;
      win_row_d = '0;
      win_col_d = '0;
      pix_row_d = '0;
      pix_col_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      flast_q   <= 1'b0;
      off_row_q <= '0;
      off_col_q <= '0;
      win_row_q <= '0;
      win_col_q <= '0;
      pix_row_q <= '0;
      pix_col_q <= '0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      first_q   <= first_d;
      last_q    <= last_d;
      flast_q   <= flast_d;
      off_row_q <= off_row_d;
      off_col_q <= off_col_d;
      win_row_q <= win_row_d;
      win_col_q <= win_col_d;
      pix_row_q <= pix_row_d;
      pix_col_q <= pix_col_d;
    end
  end

  assign scan_o.valid      = valid_q;
  assign scan_o.busy       = busy_q;
  assign scan_o.done       = done_q;
  assign scan_o.win_first  = first_q;
  assign scan_o.win_last   = last_q;
  assign scan_o.frame_last = flast_q;
  assign scan_o.win_row    = win_row_q;
  assign scan_o.win_col    = win_col_q;
  assign scan_o.pix_row    = pix_row_q;
  assign scan_o.pix_col    = pix_col_q;

endmodule

// File: tb/tb_window_scan_gen.sv
// Directed scoreboard bench for window_scan_gen over four parameter sets.
module tb_window_scan_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic ready = 1'b0;
  int   sel = 0;

  always #5 clk = ~clk;

  window_scan_if #(.ROW_W(10), .COL_W(10)) if0 ();
  window_scan_if #(.ROW_W(10), .COL_W(10)) if1 ();
  window_scan_if #(.ROW_W(10), .COL_W(10)) if2 ();
  window_scan_if #(.ROW_W(10), .COL_W(10)) if3 ();

  assign if0.start = start && (sel == 0);
  assign if1.start = start && (sel == 1);
  assign if2.start = start && (sel == 2);
  assign if3.start = start && (sel == 3);
  assign if0.ready = ready && (sel == 0);
  assign if1.ready = ready && (sel == 1);
  assign if2.ready = ready && (sel == 2);
  assign if3.ready = ready && (sel == 3);

  window_scan_gen #(
    .ROW_W(10), .COL_W(10), .IMG_ROWS(4), .IMG_COLS(4),
    .WIN_ROWS(2), .WIN_COLS(2), .STRIDE(1)
  ) u0 (.clk(clk), .rst(rst), .scan_o(if0.master));

  window_scan_gen #(
    .ROW_W(10), .COL_W(10), .IMG_ROWS(4), .IMG_COLS(4),
    .WIN_ROWS(2), .WIN_COLS(2), .STRIDE(2)
  ) u1 (.clk(clk), .rst(rst), .scan_o(if1.master));

  window_scan_gen #(
    .ROW_W(10), .COL_W(10), .IMG_ROWS(5), .IMG_COLS(5),
    .WIN_ROWS(2), .WIN_COLS(2), .STRIDE(2)
  ) u2 (.clk(clk), .rst(rst), .scan_o(if2.master));

  window_scan_gen #(
    .ROW_W(10), .COL_W(10), .IMG_ROWS(3), .IMG_COLS(3),
    .WIN_ROWS(3), .WIN_COLS(3), .STRIDE(1)
  ) u3 (.clk(clk), .rst(rst), .scan_o(if3.master));

  // {valid,busy,done,win_row,win_col,pix_row,pix_col,first,last,flast}
  logic [45:0] obs;

  always_comb begin
    obs = '0;
    case (sel)
      1: obs = {if1.valid, if1.busy, if1.done, if1.win_row, if1.win_col,
                if1.pix_row, if1.pix_col, if1.win_first, if1.win_last,
                if1.frame_last};
      2: obs = {if2.valid, if2.busy, if2.done, if2.win_row, if2.win_col,
                if2.pix_row, if2.pix_col, if2.win_first, if2.win_last,
                if2.frame_last};
      3: obs = {if3.valid, if3.busy, if3.done, if3.win_row, if3.win_col,
                if3.pix_row, if3.pix_col, if3.win_first, if3.win_last,
                if3.frame_last};
      default: obs = {if0.valid, if0.busy, if0.done, if0.win_row,
                if0.win_col, if0.pix_row, if0.pix_col, if0.win_first,
                if0.win_last, if0.frame_last};
    endcase
  end

  logic [42:0] sb[$];
  int n_pass = 0;
  int n_total = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] want);
    n_total++;
    assert (got === want) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, got, want);
  endtask

  function automatic logic [42:0] pk(int wr, int wc, int pr, int pc,
                                     bit f, bit l, bit fl);
    return {10'(wr), 10'(wc), 10'(pr), 10'(pc), f, l, fl};
  endfunction

  // Reference walk of the image: origins outer, offsets inner
  task automatic load_model(int ir, int ic, int wr, int wc, int s);
    int nwr, nwc;
    bit l;
    sb.delete();
    nwr = (ir - wr) / s + 1;
    nwc = (ic - wc) / s + 1;
    for (int a = 0; a < nwr; a++)
      for (int b = 0; b < nwc; b++)
        for (int r = 0; r < wr; r++)
          for (int c = 0; c < wc; c++) begin
            l = (r == wr - 1) && (c == wc - 1);
            sb.push_back(pk(a * s, b * s, a * s + r, b * s + c,
                            (r == 0) && (c == 0), l,
                            l && (a == nwr - 1) && (b == nwc - 1)));
          end
  endtask

  task automatic run_scan(input int k, input bit rnd, input int rst_at,
                          input bit poke, output int maxr,
                          output int lastpos);
    int got, cyc, total;
    bit held;
    logic [45:0] prev;
    logic [42:0] want;
    got = 0;
    cyc = 0;
    held = 0;
    maxr = 0;
    lastpos = 0;
    prev = '0;
    total = sb.size();
    sel = k;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (got < total && cyc < 2000) begin
      cyc++;
      if (held) check("hold", 64'(obs), 64'(prev));
      check("valid_busy", 64'(obs[45:43]), 64'(3'b110));
      if (rst_at != 0 && got == rst_at - 1) begin
        rst = 1'b1;
        @(negedge clk);
        check("mid_reset", 64'(obs), 64'd0);
        rst = 1'b0;
        ready = 1'b0;
        return;
      end
      start = poke && (cyc == 4);
      ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ready) begin
        want = sb.pop_front();
        check("beat", 64'(obs[42:0]), 64'(want));
        got++;
        if (int'(obs[22:13]) > maxr) maxr = int'(obs[22:13]);
        if (obs[1]) lastpos = got;
        held = 0;
      end else begin
        held = 1;
        prev = obs;
      end
      @(negedge clk);
    end
    ready = 1'b0;
    start = 1'b0;
    if (cyc >= 2000) check("timeout", 64'(got), 64'(total));
    check("done_pulse", 64'(obs[45:43]), 64'(3'b001));
    start = poke;
    @(negedge clk);
    start = 1'b0;
    check("idle", 64'(obs), 64'd0);
    @(negedge clk);
    check("idle_hold", 64'(obs), 64'd0);
  endtask

  int mr, lp;

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      sel = k;
      #1;
      check("reset_state", 64'(obs), 64'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    // 4x4 / 2x2 / stride 1, full-rate
    load_model(4, 4, 2, 2, 1);
    check("count36", 64'(sb.size()), 64'd36);
    run_scan(0, 1'b0, 0, 1'b0, mr, lp);
    check("flast_pos36", 64'(lp), 64'd36);

    // stride 2 on 4x4
    load_model(4, 4, 2, 2, 2);
    run_scan(1, 1'b0, 0, 1'b0, mr, lp);
    check("flast_pos16", 64'(lp), 64'd16);

    // stride 2 on 5x5: row/col 4 never visited
    load_model(5, 5, 2, 2, 2);
    run_scan(2, 1'b0, 0, 1'b0, mr, lp);
    check("max_pix_row", 64'(mr), 64'd3);

    // random backpressure, same sequence as the first scan
    load_model(4, 4, 2, 2, 1);
    run_scan(0, 1'b1, 0, 1'b0, mr, lp);

    // reset on beat 10, then a clean restart
    load_model(4, 4, 2, 2, 1);
    run_scan(0, 1'b0, 10, 1'b0, mr, lp);
    @(negedge clk);
    check("post_reset", 64'(obs), 64'd0);
    load_model(4, 4, 2, 2, 1);
    run_scan(0, 1'b0, 0, 1'b0, mr, lp);

    // window equals image; start poked in SCAN and DONE
    load_model(3, 3, 3, 3, 1);
    check("count9", 64'(sb.size()), 64'd9);
    run_scan(3, 1'b1, 0, 1'b1, mr, lp);
    check("flast_pos9", 64'(lp), 64'd9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
